vu_meter_controller: RTL and testbench

Sequences the LED-bar visualizer at frame rate instead of per-sample.
- Takes the packed stereo audio word on each sample strobe.
- Tracks the peak magnitude of the channel average over a window of WINDOW_SAMPLES samples.
- Publishes the peak once per window as a 16-LED bar with a peak-hold/decay marker.
- Sits between the audio codec receive path and the board LED outputs.

---
 rtl/vu_meter_pkg.sv | 31 +++
 rtl/vu_bar_decoder.sv | 30 +++
 rtl/vu_meter_controller.sv | 132 +++++++++++++
 tb/tb_vu_meter_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vu_meter_pkg.sv
// Shared definitions for the VU meter controller.
//   NUM_LEDS / LED_STEP : bar geometry (16 LEDs, one per 2048 counts of level)
//   state_t             : frame sequencer states
//   stereo_mag()        : |floor((L + R) / 2)| of a packed stereo word
//   onehot16()          : 4-bit index to 16-bit one-hot marker
package vu_meter_pkg;

  localparam int NUM_LEDS = 16;
  localparam int LED_STEP = 2048;

  typedef enum logic {
    ACCUM   = 1'b0,
    PUBLISH = 1'b1
  } state_t;

  // Average is taken in 17 bits so the sum of two full-scale values cannot
  // overflow; dropping the LSB of the sum is an arithmetic shift (floor).
  // The negated -32768 wraps to 16'h8000, read back as unsigned 32768.
  function automatic logic [15:0] stereo_mag(input logic [31:0] audio);
    logic [16:0] sum;
    logic [15:0] avg;
    sum = {audio[31], audio[31:16]} + {audio[15], audio[15:0]};
    avg = sum[16:1];
    stereo_mag = avg[15] ? (~avg + 16'd1) : avg;
  endfunction

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'd1 << idx;
  endfunction

endpackage

// File: rtl/vu_bar_decoder.sv
// Combinational level-to-bar decoder.
//   level     : unsigned window peak, 0..32768
//   bar       : bar[i] = level > LED_STEP*i (thermometer code)
//   top       : index of the highest lit bar segment
//   top_valid : at least one segment is lit
module vu_bar_decoder
  import vu_meter_pkg::*;
(
  input  logic [15:0] level,
  output logic [15:0] bar,
  output logic [3:0]  top,
  output logic        top_valid
);

  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_bar
      assign bar[gi] = (level > 16'(LED_STEP * gi));
    end
  endgenerate

  always_comb begin
    top = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (bar[i]) top = 4'(i);
    end
  end

  assign top_valid = |bar;

endmodule

// File: rtl/vu_meter_controller.sv
// Frame-rate VU meter sequencer.
// Accumulates the peak stereo magnitude over WINDOW_SAMPLES accepted
// samples, then spends one PUBLISH cycle updating the LED bar, the level
// word and the peak-hold marker.
//   clk, rst     : clock, synchronous active-high reset
//   sample_valid : strobe qualifying inputAudio
//   inputAudio   : [31:16] left, [15:0] right, signed
//   freeze       : holds leds/level during PUBLISH (peak hold still advances)
//   leds         : bar OR peak marker
//   level        : last published window peak
//   frame_done   : one-cycle pulse after each PUBLISH
module vu_meter_controller
  import vu_meter_pkg::*;
#(
  parameter int WINDOW_SAMPLES = 1024,
  parameter int HOLD_FRAMES    = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [31:0] inputAudio,
  input  logic        freeze,
  output logic [15:0] leds,
  output logic [15:0] level,
  output logic        frame_done
);

  localparam int CNT_W  = $clog2(WINDOW_SAMPLES);
  localparam int HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WINDOW_SAMPLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);

  state_t            state_reg, state_next;
  logic [15:0]       win_peak_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              peak_valid_reg, peak_valid_next;
  logic [3:0]        peak_idx_reg, peak_idx_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [15:0]       leds_reg, level_reg;
  logic              frame_done_reg;

  logic [15:0] mag;
  logic [15:0] bar;
  logic [3:0]  top;
  logic        top_valid;
  logic [3:0]  idx_dec;

  assign mag = stereo_mag(inputAudio);

  // The decoder looks at the completed window peak, which is stable
  // throughout the PUBLISH cycle.
  vu_bar_decoder u_bar_decoder (
    .level     (win_peak_reg),
    .bar       (bar),
    .top       (top),
    .top_valid (top_valid)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACCUM:   if (sample_valid && count_reg == LAST_CNT) state_next = PUBLISH;
      PUBLISH: state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Peak marker: a new top at or above the marker re-arms it; otherwise the
  // hold counter runs down, then the marker steps down one LED per frame.
  always_comb begin
    peak_valid_next = peak_valid_reg;
    peak_idx_next   = peak_idx_reg;
    hold_cnt_next   = hold_cnt_reg;
    idx_dec         = peak_idx_reg - 4'd1;
    if (state_reg == PUBLISH) begin
      if (top_valid && (!peak_valid_reg || top >= peak_idx_reg)) begin
        peak_idx_next   = top;
        peak_valid_next = 1'b1;
        hold_cnt_next   = HOLD_LOAD;
      end else if (hold_cnt_reg != '0) begin
        hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
      end else if (peak_valid_reg) begin
        if (peak_idx_reg == 4'd0) begin
          peak_valid_next = 1'b0;
        end else if (top_valid && top >= idx_dec) begin
          peak_idx_next = top;
          hold_cnt_next = HOLD_LOAD;
        end else begin
          peak_idx_next = idx_dec;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ACCUM;
      win_peak_reg   <= '0;
      count_reg      <= '0;
      peak_valid_reg <= 1'b0;
      peak_idx_reg   <= '0;
      hold_cnt_reg   <= '0;
      leds_reg       <= '0;
      level_reg      <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      peak_valid_reg <= peak_valid_next;
      peak_idx_reg   <= peak_idx_next;
      hold_cnt_reg   <= hold_cnt_next;
      frame_done_reg <= (state_reg == PUBLISH);

      if (state_reg == PUBLISH) begin
        // A strobe here opens the next window rather than being lost.
        win_peak_reg <= sample_valid ? mag : 16'd0;
        count_reg    <= sample_valid ? CNT_W'(1) : '0;
        if (!freeze) begin
          level_reg <= win_peak_reg;
          leds_reg  <= bar | (peak_valid_next ? onehot16(peak_idx_next) : 16'd0);
        end
      end else if (sample_valid) begin
        if (mag > win_peak_reg) win_peak_reg <= mag;
        count_reg <= (count_reg == LAST_CNT) ? '0 : count_reg + CNT_W'(1);
      end
    end
  end

  assign leds       = leds_reg;
  assign level      = level_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_vu_meter_controller.sv
module tb_vu_meter_controller;

  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [31:0] inputAudio = '0;
  logic        freeze = 1'b0;
  logic [15:0] leds;
  logic [15:0] level;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level reference state
  int   m_cnt, m_peak, m_frame_peak, m_pidx, m_hold;
  bit   m_pend, m_fd;
  int   m_leds, m_level;

  vu_meter_controller #(.WINDOW_SAMPLES(W), .HOLD_FRAMES(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .inputAudio   (inputAudio),
    .freeze       (freeze),
    .leds         (leds),
    .level        (level),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int mag_of(input logic [31:0] d);
    int l, r, s, a;
    l = int'($signed(d[31:16]));
    r = int'($signed(d[15:0]));
    s = l + r;
    a = (s >= 0) ? s / 2 : -((1 - s) / 2);   // floor division by 2
    return (a < 0) ? -a : a;
  endfunction

  function automatic int top_of(input int pk);
    int t = -1;
    for (int i = 0; i < 16; i++) if (pk > 2048 * i) t = i;
    return t;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_peak = 0; m_frame_peak = 0; m_pidx = -1; m_hold = 0;
    m_pend = 0; m_fd = 0; m_leds = 0; m_level = 0;
  endtask

  task automatic model_edge(input bit v, input logic [31:0] d, input bit fr, input bit r);
    int t, bars;
    if (r) begin
      model_reset();
      return;
    end
    m_fd = 0;
    if (m_pend) begin
      m_pend = 0;
      m_fd   = 1;
      t = top_of(m_frame_peak);
      if (t >= 0 && (m_pidx < 0 || t >= m_pidx)) begin
        m_pidx = t; m_hold = H;
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (m_pidx >= 0) begin
        m_pidx--;
        if (m_pidx >= 0 && t >= m_pidx) begin
          m_pidx = t; m_hold = H;
        end
      end
      if (!fr) begin
        bars = (t < 0) ? 0 : ((1 << (t + 1)) - 1);
        m_level = m_frame_peak;
        m_leds  = bars | ((m_pidx >= 0) ? (1 << m_pidx) : 0);
      end
    end
    if (v) begin
      if (mag_of(d) > m_peak) m_peak = mag_of(d);
      m_cnt++;
      if (m_cnt == W) begin
        m_frame_peak = m_peak;
        m_pend = 1;
        m_cnt = 0;
        m_peak = 0;
      end
    end
  endtask

  // One clock: drive, advance model on the edge, compare 1 time unit later.
  task automatic tick(input bit v, input logic [31:0] d, input bit fr, input bit r);
    sample_valid = v;
    inputAudio   = d;
    freeze       = fr;
    rst          = r;
    @(posedge clk);
    model_edge(v, d, fr, r);
    #1;
    check("frame_done", {31'd0, frame_done}, {31'd0, m_fd});
    check("leds", {16'd0, leds}, m_leds);
    check("level", {16'd0, level}, m_level);
    if (m_fd || frame_done)
      $display("frame t=%0t level=%0d leds=%h freeze=%0d", $time, level, leds, fr);
  endtask

  task automatic feed(input logic [31:0] d);
    tick(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input bit fr);
    tick(1'b0, 32'd0, fr, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  task automatic frame_of(input logic [31:0] d, input bit fr);
    for (int i = 0; i < W; i++) feed(d);
    idle(fr);
  endtask

  initial begin
    logic [15:0] exp_leds;
    model_reset();
    @(posedge clk);
    #1;

    // 1. reset with strobes toggling
    tick(1'b1, 32'h1000_1000, 1'b0, 1'b1);
    tick(1'b0, 32'h1000_1000, 1'b0, 1'b1);
    tick(1'b1, 32'h1000_1000, 1'b0, 1'b1);
    check("rst_leds", {16'd0, leds}, 32'd0);
    check("rst_level", {16'd0, level}, 32'd0);
    check("rst_fd", {31'd0, frame_done}, 32'd0);

    // 2. basic frame
    for (int i = 0; i < W; i++) feed(32'h1000_1000);
    check("t2_no_early_fd", {31'd0, frame_done}, 32'd0);
    idle(1'b0);
    check("t2_fd", {31'd0, frame_done}, 32'd1);
    check("t2_level", {16'd0, level}, 32'd4096);
    check("t2_leds", {16'd0, leds}, 32'h0003);
    idle(1'b0);
    check("t2_fd_once", {31'd0, frame_done}, 32'd0);

    // 3. sign handling
    do_reset();
    frame_of(32'h8000_8000, 1'b0);
    check("t3_level_max", {16'd0, level}, 32'd32768);
    check("t3_leds_max", {16'd0, leds}, 32'hFFFF);
    frame_of(32'h7FFF_8000, 1'b0);
    check("t3_level_m1", {16'd0, level}, 32'd1);
    check("t3_leds_m1", {16'd0, leds}, 32'h8001);

    // 4. window max, strobe during PUBLISH
    do_reset();
    feed({16'd100, 16'd100});
    feed({16'd30000, 16'd30000});
    feed({16'd5, 16'd5});
    feed(32'd0);
    feed({16'd200, 16'd200});          // lands in PUBLISH
    check("t4_level", {16'd0, level}, 32'd30000);
    check("t4_leds", {16'd0, leds}, 32'h7FFF);
    feed(32'd0);
    feed(32'd0);
    check("t4_not_yet", {31'd0, frame_done}, 32'd0);
    feed(32'd0);
    idle(1'b0);
    check("t4_fd_next", {31'd0, frame_done}, 32'd1);
    check("t4_level_next", {16'd0, level}, 32'd200);

    // 5. peak decay
    do_reset();
    for (int k = 0; k < 19; k++) begin
      frame_of((k == 0) ? 32'h8000_8000 : 32'd0, 1'b0);
      if (k == 0)       exp_leds = 16'hFFFF;
      else if (k <= 2)  exp_leds = 16'h8000;
      else if (k <= 17) exp_leds = 16'h8000 >> (k - 2);
      else              exp_leds = 16'h0000;
      check($sformatf("t5_decay%0d", k), {16'd0, leds}, {16'd0, exp_leds});
    end

    // 6a. freeze
    do_reset();
    frame_of(32'h1000_1000, 1'b0);
    frame_of(32'h4000_4000, 1'b1);
    check("t6_frz_fd", {31'd0, frame_done}, 32'd1);
    check("t6_frz_level", {16'd0, level}, 32'd4096);
    check("t6_frz_leds", {16'd0, leds}, 32'h0003);
    frame_of(32'd0, 1'b0);
    check("t6_after_frz_leds", {16'd0, leds}, 32'h0080);

    // 6b. mid-window reset
    do_reset();
    feed(32'h2000_2000);
    feed(32'h2000_2000);
    do_reset();
    for (int i = 0; i < W - 1; i++) feed(32'h2000_2000);
    idle(1'b0);
    check("t6_rst_nofd", {31'd0, frame_done}, 32'd0);
    feed(32'h2000_2000);
    idle(1'b0);
    check("t6_rst_fd", {31'd0, frame_done}, 32'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = 32'h8000_8000;
        2: d = 32'd0;
        default: d = {16'($urandom_range(0, 4095)), 16'($urandom_range(0, 4095))};
      endcase
      tick($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
